fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction fetch stage for the RV64I core. Feeds the main decoder: holds the PC and
//   fetches one 32-bit instruction at a time over a req/ack handshake to instruction memory.
//   Presents each instruction with its PC until decode accepts it. Takes pc_src/pc_target
//   back from the decode/execute side to choose the next PC.
//   Non-pipelined: one outstanding fetch, minimum 2 cycles per instruction.
// PARAMETERS
//   XLEN      64        PC / address width
//   RESET_PC  64'h0     PC loaded on reset
// PORTS
//   clk            in   1     clock; all state updates on rising edge
//   rst            in   1     reset: synchronous, active-high
//   imem_req       out  1     fetch request, valid while in FETCH
//   imem_addr      out  XLEN  fetch address (= pc), stable while imem_req=1
//   imem_ack       in   1     memory returns imem_rdata this cycle
//   imem_rdata     in   32    instruction word, sampled only when imem_req & imem_ack
//   inst_valid     out  1     inst/inst_pc/inst_pc_plus4 valid for decode
//   inst           out  32    fetched instruction
//   inst_pc        out  XLEN  PC of inst
//   inst_pc_plus4  out  XLEN  inst_pc + 4 (link value for jal/jalr)
//   stall          in   1     decode not ready; holds the current instruction
//   pc_src         in   1     1 = redirect to pc_target; sampled only on consume
//   pc_target      in   XLEN  branch/jump target; sampled only on consume with pc_src=1
//   fault          out  1     sticky misaligned-target fault
//   inst_count     out  XLEN  number of instructions consumed since reset
// BEHAVIOUR
//   Reset (rst=1 at clk edge):
//   - pc=RESET_PC, state=FETCH, inst_valid=0, inst=32'h00000013 (nop), inst_pc=RESET_PC.
//   - fault=0, inst_count=0.
//   - While rst is asserted, imem_req is forced to 0.
//   - Any outstanding request is abandoned; an ack arriving after reset is ignored unless
//     the stage is again in FETCH.
//   States (2-bit registered): FETCH, ISSUE, HALT.
//   - FETCH:
//     - imem_req=1, imem_addr=pc; both held until imem_ack.
//     - On imem_ack: inst<=imem_rdata, inst_pc<=pc, inst_pc_plus4<=pc+4, inst_valid<=1,
//       go to ISSUE.
//     - Ack in the request cycle (zero-wait memory) is legal; inst_valid rises on the next
//       cycle.
//   - ISSUE:
//     - imem_req=0, inst_valid=1, outputs stable.
//     - Consume = inst_valid & ~stall.
//       - pc <= pc_src ? {pc_target[XLEN-1:1],1'b0} : pc+4.
//       - inst_valid<=0, inst_count<=inst_count+1, go to FETCH.
//     - stall=1: hold all outputs and state, for any number of cycles.
//   - HALT:
//     - imem_req=0, inst_valid=0, fault=1. Left only by reset.
//   Redirect rules:
//   - Target bit0 is always cleared (jalr semantics).
//   - If the masked target has bit1=1 on consume: pc is unchanged, inst_count still
//     increments, fault<=1, go to HALT.
//   - pc_src and pc_target are ignored whenever consume=0.
//   Arithmetic:
//   - pc+4 and inst_count wrap modulo 2^XLEN, with no flag.
//   - PC at all-ones minus 3 wraps to 0.
//   Ignored inputs:
//   - imem_ack outside FETCH is ignored.
//   - imem_rdata is not sampled without ack.
//   Simultaneous events:
//   - rst has priority over everything, including consume and ack in the same cycle.
// TESTING
//   1. Reset with RESET_PC=0, zero-wait ack, rdata=0x00000013 -> imem_addr=0 in the first
//      post-reset cycle; next cycle inst_valid=1, inst=0x13, inst_pc=0, inst_pc_plus4=4.
//   2. Three consumes, stall=0, pc_src=0 -> imem_addr sequence 0,4,8; inst_count=3;
//      inst_valid toggles 0/1 each cycle.
//   3. stall=1 for 3 cycles in ISSUE -> inst/inst_pc unchanged, imem_req=0,
//      inst_count unchanged; consumed on the 4th cycle.
//   4. Consume with pc_src=1, pc_target=0x100 -> next imem_addr=0x100.
//      pc_target=0x101 -> imem_addr=0x100.
//      pc_target=0x102 -> fault=1, state HALT, imem_req stays 0 until rst.
//   5. Ack delayed 4 cycles -> imem_req=1 and imem_addr constant for all 5 cycles;
//      inst_valid=0 until the cycle after ack.
//   6. rst pulsed mid-FETCH at pc=0x8 -> imem_req=0 while rst=1, then imem_addr=RESET_PC;
//      a stale ack during rst is dropped; fault and inst_count cleared.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage for the RV64I core.
// Keeps the PC, fetches one 32-bit word at a time over a req/ack handshake,
// and presents it with its PC until decode consumes it. Misaligned redirect
// targets stop the stage in HALT, and only reset leaves HALT.
module fetch_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            fault,
  output logic [XLEN-1:0] inst_count
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    ISSUE = 2'b01,
    HALT  = 2'b10
  } state_t;

  localparam logic [31:0]     NOP_INST   = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0] CNT_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] BIT0_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};

  state_t            state_r;
  state_t            state_s;
  logic [XLEN-1:0]   pc_r;
  logic [31:0]       inst_r;
  logic [XLEN-1:0]   inst_pc_r;
  logic [XLEN-1:0]   inst_pc_plus4_r;
  logic              inst_valid_r;
  logic              fault_r;
  logic [XLEN-1:0]   inst_count_r;

  logic              capture_s;
  logic              consume_s;
  logic              misalign_s;
  logic [XLEN-1:0]   target_s;
  logic [XLEN-1:0]   pc_plus4_s;
  logic [XLEN-1:0]   next_pc_s;

  // Redirect target with bit0 cleared (jalr semantics) and the sequential successor.
  always_comb begin
    target_s   = pc_target & BIT0_CLEAR;
    pc_plus4_s = pc_r + PC_STEP;
    next_pc_s  = pc_plus4_s;
    if (pc_src) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Next-state logic and the capture/consume strobes for the datapath.
  always_comb begin
    state_s    = state_r;
    capture_s  = 1'b0;
    consume_s  = 1'b0;
    misalign_s = 1'b0;
    case (state_r)
      FETCH: begin
        if (imem_ack) begin
          capture_s = 1'b1;
          state_s   = ISSUE;
        end else begin
          state_s   = FETCH;
        end
      end
      ISSUE: begin
        if (inst_valid_r && !stall) begin
          consume_s = 1'b1;
          if (pc_src && target_s[1]) begin
            misalign_s = 1'b1;
            state_s    = HALT;
          end else begin
            state_s    = FETCH;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        state_s = FETCH;
      end
    endcase
  end

  // State register; reset returns to FETCH and abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // PC, instruction latch, fault flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r            <= RESET_PC;
      inst_r          <= NOP_INST;
      inst_pc_r       <= RESET_PC;
      inst_pc_plus4_r <= RESET_PC + PC_STEP;
      inst_valid_r    <= 1'b0;
      fault_r         <= 1'b0;
      inst_count_r    <= {XLEN{1'b0}};
    end else if (capture_s) begin
      inst_r          <= imem_rdata;
      inst_pc_r       <= pc_r;
      inst_pc_plus4_r <= pc_plus4_s;
      inst_valid_r    <= 1'b1;
    end else if (consume_s) begin
      inst_valid_r    <= 1'b0;
      inst_count_r    <= inst_count_r + CNT_ONE;
      if (misalign_s) begin
        fault_r <= 1'b1;
      end else begin
        pc_r    <= next_pc_s;
      end
    end else begin
      pc_r <= pc_r;
    end
  end

  assign imem_req      = (state_r == FETCH) && !rst;
  assign imem_addr     = pc_r;
  assign inst_valid    = inst_valid_r;
  assign inst          = inst_r;
  assign inst_pc       = inst_pc_r;
  assign inst_pc_plus4 = inst_pc_plus4_r;
  assign fault         = fault_r;
  assign inst_count    = inst_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage. A transaction-level model
// (expected PC, consumed count, halted flag) predicts every output, and the
// bench steps through fetch, ack delay, stall, consume, halt and reset phases.
module tb_fetch_stage;

  localparam int          XLEN   = 64;
  localparam logic [63:0] RPC    = 64'h0;
  localparam logic [63:0] ALL_FC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [63:0] inst_pc_plus4;
  logic        stall;
  logic        pc_src;
  logic [63:0] pc_target;
  logic        fault;
  logic [63:0] inst_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc;
  logic [63:0] m_cnt;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_plus4(inst_pc_plus4),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .fault(fault), .inst_count(inst_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetching(input string tag);
    check_eq({tag, "_req"},   {63'd0, imem_req},   64'd1);
    check_eq({tag, "_addr"},  imem_addr,           m_pc);
    check_eq({tag, "_valid"}, {63'd0, inst_valid}, 64'd0);
    check_eq({tag, "_cnt"},   inst_count,          m_cnt);
    check_eq({tag, "_fault"}, {63'd0, fault},      64'd0);
  endtask

  // Reset with an ack present in the same cycle; the ack must be dropped.
  task automatic do_reset(input logic stale_ack);
    rst        = 1'b1;
    imem_ack   = stale_ack;
    imem_rdata = $urandom;
    stall      = 1'($urandom);
    #1;
    check_eq("rst_req_low", {63'd0, imem_req}, 64'd0);
    tick;
    rst      = 1'b0;
    imem_ack = 1'b0;
    #1;
    m_pc  = RPC;
    m_cnt = 64'd0;
    check_fetching("post_rst");
    check_eq("post_rst_inst",   {32'd0, inst}, 64'h13);
    check_eq("post_rst_instpc", inst_pc,       RPC);
  endtask

  initial begin
    logic [31:0] w;
    logic [63:0] t;
    logic        src;
    int          d;
    int          s;

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
    pc_src = 1'b0; pc_target = 64'd0;
    tick;
    do_reset(1'b0);

    for (int i = 0; i < 300; i++) begin
      // Ack delay: directed 4-cycle wait once, zero-wait first, random otherwise.
      d = (i == 0) ? 0 : (i == 1) ? 4 : $urandom_range(0, 4);
      for (int k = 0; k < d; k++) begin
        check_fetching("fetch_wait");
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        tick;
      end

      // Reset mid-FETCH with a stale ack in the reset cycle.
      if (i % 13 == 6) begin
        do_reset(1'b1);
        continue;
      end

      check_fetching("fetch_ack");
      w          = (i == 0) ? 32'h0000_0013 : $urandom;
      imem_ack   = 1'b1;
      imem_rdata = w;
      tick;
      imem_ack = 1'b0;

      // ISSUE with random stall; ack, pc_src and target are noise here.
      s = (i == 2) ? 3 : $urandom_range(0, 3);
      for (int k = 0; k <= s; k++) begin
        check_eq("issue_valid",  {63'd0, inst_valid}, 64'd1);
        check_eq("issue_req",    {63'd0, imem_req},   64'd0);
        check_eq("issue_inst",   {32'd0, inst},       {32'd0, w});
        check_eq("issue_pc",     inst_pc,             m_pc);
        check_eq("issue_pc4",    inst_pc_plus4,       m_pc + 64'd4);
        check_eq("issue_cnt",    inst_count,          m_cnt);
        check_eq("issue_fault",  {63'd0, fault},      64'd0);
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        if (k < s) begin
          stall     = 1'b1;
          pc_src    = 1'b1;
          pc_target = 64'h2;
          tick;
        end
      end

      // Consume with a chosen redirect.
      if (i % 17 == 9) begin
        src = 1'b1; t = 64'h102;
      end else if (i == 3) begin
        src = 1'b1; t = ALL_FC;
      end else if (i == 4) begin
        src = 1'b0; t = 64'h102;
      end else if (i == 5) begin
        src = 1'b1; t = 64'h101;
      end else begin
        src = 1'($urandom);
        t   = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFD;
      end
      stall     = 1'b0;
      pc_src    = src;
      pc_target = t;
      tick;
      imem_ack = 1'b0;
      pc_src   = 1'b0;

      m_cnt = m_cnt + 64'd1;
      if (src && t[1]) begin
        for (int k = 0; k < 3; k++) begin
          check_eq("halt_req",   {63'd0, imem_req},   64'd0);
          check_eq("halt_valid", {63'd0, inst_valid}, 64'd0);
          check_eq("halt_fault", {63'd0, fault},      64'd1);
          check_eq("halt_cnt",   inst_count,          m_cnt);
          check_eq("halt_pc",    imem_addr,           m_pc);
          imem_ack = 1'($urandom);
          tick;
        end
        do_reset(1'b0);
      end else if (src) begin
        m_pc = t & 64'hFFFF_FFFF_FFFF_FFFE;
      end else begin
        m_pc = m_pc + 64'd4;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
